// File: rtl/pipe_skid_stage_pkg.sv
// Shared stage-bundle types for the 5-stage core pipeline registers.
// DATA_W of each pipe_skid_stage instance is set with $bits() of these bundles.
package pipe_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;

    // Bubble bundle for IF/ID: keeps the pc for debug, injects a NOP.
    function automatic if_id_t if_id_bubble(input logic [31:0] pc);
        if_id_t b;
        b.pc    = pc;
        b.instr = NOP_INSTR;
        return b;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         clr_n_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment when enabled, sticking at all-ones.
    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register; clear is sampled on the clock edge.
    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register: main reg drives the outputs, a one-deep
// skid reg absorbs the beat that arrives in the cycle downstream stalls.
// in_ready is registered, so out_ready never reaches in_ready combinationally.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cycles
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q,  in_ready_d;

    logic acc;
    logic pop;

    assign acc = in_valid & in_ready_q;
    assign pop = out_valid_q & out_ready;

    // Next-state for main/skid storage; flush overrides any handshake.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            if (CLEAR_ON_FLUSH) begin
                out_data_d  = '0;
                skid_data_d = '0;
            end
        end else if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                // in_ready_q is low whenever skid is full, so acc cannot fire here.
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = acc;
                if (acc) begin
                    out_data_d = in_data;
                end
            end
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end

        in_ready_d = ~skid_valid_d;
    end

    // Storage registers with synchronous reset taking priority over flush.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk),
        .clr_n_i (reset_n),
        .en_i    (out_valid_q & ~out_ready),
        .count_o (stall_cycles)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
